// File: rtl/serial_negator_pkg.sv
// serial_negator_pkg: shared state encoding and mode constants for the serial negator
package serial_negator_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam logic MODE_ONES = 1'b0;
    localparam logic MODE_TWOS = 1'b1;
endpackage

// File: rtl/serial_negator_neg_bit_cell.sv
// neg_bit_cell: one-bit negation step, the serial-capable form of the plain inverter
module neg_bit_cell
    import serial_negator_pkg::*;
(
    input  logic bit_in,
    input  logic mode,
    input  logic seen_one,
    output logic bit_out,
    output logic seen_one_next
);
    always_comb begin
        bit_out       = (mode == MODE_TWOS && !seen_one) ? bit_in : ~bit_in;
        seen_one_next = seen_one | bit_in;
    end
endmodule

// File: rtl/serial_negator.sv
// serial_negator: LSB-first bit-serial ones'/two's complement negator with valid/ready
module serial_negator
    import serial_negator_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             overflow,
    output logic             zero,
    output logic             busy
);
    state_t             state;
    logic [WIDTH-1:0]   sr;
    logic [WIDTH-2:0]   res;
    logic [WIDTH-1:0]   nxt;
    logic [CNT_W-1:0]   cnt;
    logic               m, seen, ovf, b, sn;

    neg_bit_cell u_cell (
        .bit_in       (sr[0]),
        .mode         (m),
        .seen_one     (seen),
        .bit_out      (b),
        .seen_one_next(sn)
    );

    // result enters at the MSB end; after the last bit nxt is the full word
    assign nxt       = {b, res};
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sr       <= '0;
            res      <= '0;
            cnt      <= '0;
            m        <= MODE_ONES;
            seen     <= 1'b0;
            ovf      <= 1'b0;
            out_data <= '0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sr    <= in_data;
                    m     <= mode;
                    cnt   <= '0;
                    seen  <= 1'b0;
                    ovf   <= mode == MODE_TWOS && in_data == {1'b1, {(WIDTH-1){1'b0}}};
                    state <= SHIFT;
                end
                SHIFT: begin
                    sr   <= sr >> 1;
                    res  <= nxt[WIDTH-1:1];
                    seen <= sn;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH-1)) begin
                        out_data <= nxt;
                        zero     <= nxt == '0;
                        overflow <= ovf;
                        state    <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_negator.sv
// tb_serial_negator: directed self-checking bench for serial_negator at WIDTH=8
module tb_serial_negator;
    logic       clk = 0, rst_n = 0;
    logic       in_valid = 0, mode = 0, out_ready = 0;
    logic [7:0] in_data = 0;
    logic       in_ready, out_valid, overflow, zero, busy;
    logic [7:0] out_data;
    int         tests = 0, fails = 0, cyc = 0;

    serial_negator #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .overflow(overflow), .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // present an operand, count edges (accepting edge = 1) until out_valid, check result
    task automatic op(input string tag, input logic [7:0] d, input logic md,
                      input logic [7:0] ed, input logic eo, input logic ez);
        int n;
        out_ready = 0;
        @(negedge clk);
        check({tag, "_rdy"}, in_ready, 1);
        in_data = d; mode = md; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0; in_data = ~d; mode = ~md;
        n = 1;
        while (!out_valid && n < 30) begin
            check({tag, "_nordy"}, in_ready, 0);
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"}, n, 9);
        check({tag, "_data"}, out_data, ed);
        check({tag, "_ovf"}, overflow, eo);
        check({tag, "_zero"}, zero, ez);
        check({tag, "_rdy_done"}, in_ready, 0);
        check({tag, "_busy"}, busy, 1);
    endtask

    task automatic drain(input string tag);
        @(negedge clk); out_ready = 1;
        @(posedge clk); #1;
        check({tag, "_ov_low"}, out_valid, 0);
        check({tag, "_idle_rdy"}, in_ready, 1);
        check({tag, "_idle_busy"}, busy, 0);
        out_ready = 0;
    endtask

    logic [7:0] bd [3] = '{8'h03, 8'h03, 8'h7F};
    logic       bm [3] = '{1'b1, 1'b0, 1'b1};
    logic [7:0] be [3] = '{8'hFD, 8'hFC, 8'h81};

    initial begin
        int k, kin, last;
        #12;
        check("rst_rdy", in_ready, 1);
        check("rst_ov", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_ovf", overflow, 0);
        check("rst_zero", zero, 0);
        check("rst_busy", busy, 0);
        @(negedge clk); rst_n = 1;

        op("t05", 8'h05, 1, 8'hFB, 0, 0); drain("t05");
        op("t80", 8'h80, 1, 8'h80, 1, 0); drain("t80");

        // abandon an operation after 3 SHIFT edges
        @(negedge clk); in_data = 8'h55; mode = 1; in_valid = 1;
        @(posedge clk); #1 in_valid = 0;
        repeat (3) @(posedge clk);
        #2 rst_n = 0; #1;
        check("mid_ov", out_valid, 0);
        check("mid_rdy", in_ready, 1);
        check("mid_busy", busy, 0);
        check("mid_data", out_data, 0);
        check("mid_ovf", overflow, 0);
        check("mid_zero", zero, 0);
        @(negedge clk); rst_n = 1;
        repeat (2) @(negedge clk);
        check("mid_nov", out_valid, 0);
        op("t01", 8'h01, 1, 8'hFF, 0, 0); drain("t01");

        op("t00", 8'h00, 1, 8'h00, 0, 1); drain("t00");
        op("oFF", 8'hFF, 0, 8'h00, 0, 1); drain("oFF");
        op("o5A", 8'h5A, 0, 8'hA5, 0, 0); drain("o5A");
        op("o80", 8'h80, 0, 8'h7F, 0, 0); drain("o80");

        // backpressure with a stray in_valid pulse while not ready
        op("bp", 8'h33, 1, 8'hCD, 0, 0);
        for (int i = 0; i < 5; i++) begin
            in_valid = i == 2; in_data = 8'h11;
            @(posedge clk); #1;
            check("bp_ov", out_valid, 1);
            check("bp_data", out_data, 8'hCD);
            check("bp_ovf", overflow, 0);
            check("bp_zero", zero, 0);
            check("bp_rdy", in_ready, 0);
        end
        in_valid = 0;
        drain("bp");
        repeat (2) @(negedge clk);
        check("bp_ignored", busy, 0);

        // back-to-back with out_ready high
        out_ready = 1; k = 0; kin = 0; last = 0;
        for (int i = 0; i < 60 && k < 3; i++) begin
            @(negedge clk);
            if (out_valid) begin
                check("b2b_data", out_data, be[k]);
                if (k > 0) check("b2b_period", cyc - last, 10);
                last = cyc; k++;
            end
            if (in_ready) begin
                if (kin < 3) begin
                    in_data = bd[kin]; mode = bm[kin]; in_valid = 1; kin++;
                end else in_valid = 0;
            end
        end
        in_valid = 0;
        check("b2b_count", k, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/serial_negator.md
Name: serial_negator

Overview:
- Parametrised, bit-serial successor to the single-bit inverter cell. Negates a WIDTH-bit operand one bit per clock, LSB first.
- Two modes: ones' complement (invert every bit) or two's complement (copy bits up to and including the first 1, invert the rest).
- Valid/ready handshakes on input and output, so it drops into the datapath between a register-file read and the ALU result bus.
- Flags two's-complement overflow and zero result.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH), bit-index counter width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand present on in_data/mode.
- in_ready  output  1  block can accept an operand.
- in_data  input  WIDTH  operand, two's-complement signed.
- mode  input  1  0 = ones' complement, 1 = two's complement; sampled with in_data.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  negated result.
- overflow  output  1  two's mode and operand == most-negative value (1 followed by WIDTH-1 zeros).
- zero  output  1  out_data == 0.
- busy  output  1  state != IDLE.

Behaviour:
- Interface reset: one clock; reset asynchronous, active-low.
- Reset values: in_ready=1, out_valid=0, out_data=0, overflow=0, zero=0, busy=0, state=IDLE, counter=0, seen_one=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: load shift register with in_data, latch mode, clear counter and seen_one, latch overflow = mode && (in_data == {1,0...0}), go to SHIFT.
- SHIFT:
  - in_ready=0.
  - Each edge processes bit `counter` (LSB first).
  - Ones' mode: out_bit = ~bit.
  - Two's mode: out_bit = seen_one ? ~bit : bit; seen_one_next = seen_one | bit.
  - Result bit is shifted into the result register from the MSB end; counter increments.
  - When counter == WIDTH-1 is processed, go to DONE.
  - Exactly WIDTH edges are spent in SHIFT.
- DONE:
  - out_valid=1.
  - out_data, overflow and zero are registered on DONE entry and held stable while out_valid && !out_ready.
  - On out_valid&&out_ready at an edge: out_valid drops and state returns to IDLE.
  - out_data keeps its last value; it is meaningful only while out_valid=1.
- Latency and throughput:
  - out_valid rises WIDTH+1 edges after the accepting edge.
  - Minimum occupancy is WIDTH+2 cycles per operand.
  - No input/output overlap and no bypass: in_ready=0 throughout SHIFT and DONE.
- in_valid while in_ready=0 is ignored. The upstream holds in_data and mode until accepted.
- mode and in_data changes after acceptance have no effect on the operation in flight.
- Arithmetic:
  - Result is modulo 2^WIDTH.
  - Two's negation of the most-negative value returns that same value with overflow=1.
  - Two's negation of 0 returns 0, overflow=0, zero=1.
  - Ones' negation never sets overflow; it yields 0 only for an all-ones input.
- Reset mid-operation (any state): the in-flight operation is abandoned with no output, and all registers return to reset values immediately.
- out_ready while out_valid=0 has no effect.

Decomposition:
- Package serial_negator_pkg:
  - state enum (IDLE, SHIFT, DONE).
  - constants MODE_ONES=1'b0 and MODE_TWOS=1'b1.
- Sub-module neg_bit_cell: combinational one-bit cell.
  - Inputs: bit_in, mode, seen_one.
  - Outputs: bit_out, seen_one_next.
  - It is the serial-capable generalisation of the single-bit inverter and is instantiated once in the datapath.

Test Plan (WIDTH=8):
- Two's mode, in_data=0x05 accepted -> out_valid rises 9 edges later with out_data=0xFB, overflow=0, zero=0; in_ready low throughout SHIFT and DONE.
- Two's mode, in_data=0x80 -> out_data=0x80, overflow=1; then in_data=0x00 -> out_data=0x00, zero=1, overflow=0.
- Ones' mode, in_data=0xFF -> out_data=0x00, zero=1, overflow=0; in_data=0x5A -> out_data=0xA5.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_data, overflow and zero are stable; in_ready stays 0; a second in_valid pulse is ignored. Then out_ready=1 -> IDLE next edge with in_ready=1.
- Reset mid-operation: assert rst_n=0 after 3 SHIFT cycles -> all outputs reset immediately with no out_valid. After release, a new 0x01 in two's mode yields 0xFF.
- Back-to-back operands with out_ready tied high -> one result per 10 cycles, with mode changes between operands honoured.
